// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and priority helper for the interrupt controller.
package irq_pkg;

   localparam int unsigned NUM_LEVELS = 7;

   // Register word offsets (addr[7:1])
   localparam logic [6:0] REG_PENDING = 7'd0;
   localparam logic [6:0] REG_MASK    = 7'd1;
   localparam logic [6:0] REG_VBASE   = 7'd2;
   localparam logic [6:0] REG_STATUS  = 7'd3;

   localparam logic [7:0] SPURIOUS_VECTOR = 8'h18;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   // Index (1..7) of the highest set bit, 0 when none is set.
   function automatic logic [2:0] highest_level(input logic [NUM_LEVELS-1:0] v);
      highest_level = 3'd0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         if (v[i]) highest_level = 3'(i + 1);
      end
   endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Optional per-bit synchronizer followed by a registered rising-edge detector.
module irq_edge_sync
   import irq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 0,
   parameter int unsigned WIDTH       = NUM_LEVELS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_irq,
   output logic [WIDTH-1:0] o_rise
);

   logic [WIDTH-1:0] w_irq_s;
   logic [WIDTH-1:0] r_irq_q;
   logic [WIDTH-1:0] r_rise;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign w_irq_s = i_irq;
   end else begin : g_sync
      logic [WIDTH-1:0] r_sync [SYNC_STAGES];

      // Synchronizer shift chain
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
         end else begin
            r_sync[0] <= i_irq;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
         end
      end

      assign w_irq_s = r_sync[SYNC_STAGES-1];
   end

   // Previous-sample register and registered rise pulse; irq_q resets to 0 so a
   // line held high across reset release counts as one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_q <= '0;
         r_rise  <= '0;
      end else begin
         r_irq_q <= w_irq_s;
         r_rise  <= w_irq_s & ~r_irq_q;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/irq_ctrl.sv
// Seven-level 68000 interrupt controller: pending/mask/vbase registers,
// priority encoder driving ipl_n, and a bus access FSM answering IACK cycles.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 0,
   parameter logic [7:0]  RESET_VBASE = 8'h40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  irq,
   input  logic [15:0] data_write,
   output logic [15:0] data_read,
   input  logic [7:0]  addr,
   input  logic        uds,
   input  logic        lds,
   input  logic        rw,
   input  logic        iack,
   output logic        ack,
   output logic [2:0]  ipl_n
);

   logic [6:0]  w_rise;
   logic [6:0]  r_pending;
   logic [6:0]  r_mask;
   logic [7:0]  r_vbase;
   state_t      r_state;
   logic        r_ack;
   logic [15:0] r_data_read;
   logic [2:0]  r_ipl_n;

   logic        w_access;
   logic [6:0]  w_word;
   logic [2:0]  w_iack_level;
   logic [6:0]  w_iack_sel;
   logic        w_iack_hit;
   logic [7:0]  w_vector;
   logic [2:0]  w_cur_level;
   logic [6:0]  w_clr;
   logic [15:0] w_read_data;
   logic        w_unused;

   irq_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .WIDTH       (NUM_LEVELS)
   ) u_edge_sync (
      .clk    (clk),
      .reset  (reset),
      .i_irq  (irq),
      .o_rise (w_rise)
   );

   assign w_access     = (r_state == S_IDLE) && (uds || lds || iack);
   assign w_word       = addr[7:1];
   assign w_iack_level = addr[3:1];
   // One-hot of level L at bit L-1; level 0 selects nothing
   assign w_iack_sel   = 7'((8'b1 << w_iack_level) >> 1);
   assign w_iack_hit   = |(w_iack_sel & r_pending);
   assign w_vector     = r_vbase + {5'd0, w_iack_level};
   assign w_cur_level  = highest_level(r_pending & r_mask);
   assign w_unused     = ^{data_write[15:8], addr[0]};

   // Pending bits cleared this cycle by W1C or a successful IACK
   always_comb begin
      w_clr = '0;
      if (w_access) begin
         if (iack) begin
            w_clr = w_iack_sel & r_pending;
         end else if (!rw && lds && (w_word == REG_PENDING)) begin
            w_clr = data_write[6:0];
         end
      end
   end

   // Register read mux
   always_comb begin
      w_read_data = 16'd0;
      case (w_word)
         REG_PENDING: w_read_data = {9'd0, r_pending};
         REG_MASK:    w_read_data = {9'd0, r_mask};
         REG_VBASE:   w_read_data = {8'd0, r_vbase};
         REG_STATUS:  w_read_data = {13'd0, w_cur_level};
         default:     w_read_data = 16'd0;
      endcase
   end

   // Pending set/clear; a new rise wins over a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_pending <= '0;
      else       r_pending <= (r_pending & ~w_clr) | w_rise;
   end

   // Registered active-low priority level to the CPU
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_ipl_n <= 3'b111;
      else       r_ipl_n <= ~w_cur_level;
   end

   // Access FSM: one side effect and one ack per strobe assertion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ack       <= 1'b0;
         r_data_read <= 16'd0;
         r_mask      <= '0;
         r_vbase     <= RESET_VBASE;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ack <= 1'b0;
               if (w_access) begin
                  r_state <= S_BUSY;
                  r_ack   <= 1'b1;
                  if (iack) begin
                     r_data_read <= w_iack_hit ? {8'd0, w_vector} : {8'd0, SPURIOUS_VECTOR};
                  end else if (rw) begin
                     r_data_read <= w_read_data;
                  end else if (lds) begin
                     if (w_word == REG_MASK)  r_mask  <= data_write[6:0];
                     if (w_word == REG_VBASE) r_vbase <= data_write[7:0];
                  end
               end
            end
            S_BUSY: begin
               r_ack <= 1'b0;
               if (!uds && !lds && !iack) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_ack   <= 1'b0;
            end
         endcase
      end
   end

   assign data_read = r_data_read;
   assign ack       = r_ack;
   assign ipl_n     = r_ipl_n;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the controller.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  irq;
   logic [15:0] data_write;
   logic [15:0] data_read;
   logic [7:0]  addr;
   logic        uds, lds, rw, iack;
   logic        ack;
   logic [2:0]  ipl_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_ctrl #(
      .SYNC_STAGES (0),
      .RESET_VBASE (8'h40)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .data_write (data_write),
      .data_read  (data_read),
      .addr       (addr),
      .uds        (uds),
      .lds        (lds),
      .rw         (rw),
      .iack       (iack),
      .ack        (ack),
      .ipl_n      (ipl_n)
   );

   // Reference model state
   logic [6:0]  m_pend, m_mask, m_rise_pipe, m_irq_prev;
   logic [7:0]  m_vbase;
   logic        m_busy, m_ack;
   logic [15:0] m_rd;
   logic [2:0]  m_ipl_n;

   function automatic int top_level(input logic [6:0] p, input logic [6:0] m);
      for (int l = 7; l >= 1; l--) if (p[l-1] && m[l-1]) return l;
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = 0; m_mask = 0; m_vbase = 8'h40; m_rise_pipe = 0; m_irq_prev = 0;
      m_busy = 0; m_ack = 0; m_rd = 0; m_ipl_n = 3'b111;
   endtask

   // One clock edge of the controller's documented behaviour
   task automatic model_edge();
      logic [6:0] clr;
      logic [2:0] lv;
      int lvl;
      clr = 0;
      lvl = top_level(m_pend, m_mask);
      m_ipl_n = ~3'(lvl);
      if (!m_busy && (uds || lds || iack)) begin
         m_busy = 1; m_ack = 1;
         if (iack) begin
            lv = addr[3:1];
            if (lv != 0 && m_pend[lv-1]) begin
               m_rd = {8'd0, 8'(m_vbase + 8'(lv))};
               clr[lv-1] = 1'b1;
            end else m_rd = 16'h0018;
         end else if (rw) begin
            case (int'(addr[7:1]))
               0: m_rd = {9'd0, m_pend};
               1: m_rd = {9'd0, m_mask};
               2: m_rd = {8'd0, m_vbase};
               3: m_rd = 16'(lvl);
               default: m_rd = 16'd0;
            endcase
         end else if (lds) begin
            case (int'(addr[7:1]))
               0: clr = data_write[6:0];
               1: m_mask = data_write[6:0];
               2: m_vbase = data_write[7:0];
               default: ;
            endcase
         end
      end else begin
         m_ack = 0;
         if (!(uds || lds || iack)) m_busy = 0;
      end
      m_pend = (m_pend & ~clr) | m_rise_pipe;
      m_rise_pipe = irq & ~m_irq_prev;
      m_irq_prev = irq;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_bus();
      uds = 0; lds = 0; iack = 0; rw = 1; addr = 0; data_write = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      irq = 0; idle_bus();
      do_reset();
      checks++; if (data_read !== 16'd0) begin errors++; $display("FAIL reset_data_read: got %h want 0000", data_read); end
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
      checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL reset_ipl_n: got %b want 111", ipl_n); end
   endtask

   task automatic test_mask();
      irq = 7'h10; step(); irq = 0; step(); step();
      addr = 8'h00; rw = 1; lds = 1; step();
      checks++; if (data_read !== 16'h0010 || data_read !== m_rd) begin errors++;
         $display("FAIL mask_pending_read: got %h want 0010 (model %h)", data_read, m_rd); end
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mask_read_ack: got %b want 1", ack); end
      idle_bus(); step();
      checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL masked_ipl_n: got %b want 111", ipl_n); end
      addr = 8'h02; rw = 0; lds = 1; data_write = 16'h0010; step();
      idle_bus(); step();
      checks++; if (ipl_n !== 3'b010 || ipl_n !== m_ipl_n) begin errors++;
         $display("FAIL unmasked_ipl_n: got %b want 010 (model %b)", ipl_n, m_ipl_n); end
      // Clear everything and enable all levels
      addr = 8'h00; rw = 0; lds = 1; data_write = 16'h007F; step(); idle_bus(); step();
      addr = 8'h02; rw = 0; lds = 1; data_write = 16'h007F; step(); idle_bus(); step();
   endtask

   task automatic test_priority_iack();
      irq = 7'h22; step(); irq = 0; step(); step();
      checks++; if (ipl_n !== 3'b001) begin errors++; $display("FAIL prio_ipl_n: got %b want 001", ipl_n); end
      iack = 1; addr = 8'h0C; step();
      checks++; if (data_read !== 16'h0046 || data_read !== m_rd) begin errors++;
         $display("FAIL iack_vector: got %h want 0046 (model %h)", data_read, m_rd); end
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL iack_ack: got %b want 1", ack); end
      idle_bus(); step();
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL iack_ack_drop: got %b want 0", ack); end
      checks++; if (ipl_n !== 3'b101) begin errors++; $display("FAIL iack_ipl_n: got %b want 101", ipl_n); end
   endtask

   task automatic test_spurious();
      addr = 8'h00; rw = 0; lds = 1; data_write = 16'h007F; step(); idle_bus(); step();
      iack = 1; addr = 8'h06; step();
      checks++; if (data_read !== 16'h0018) begin errors++; $display("FAIL spurious_vector: got %h want 0018", data_read); end
      idle_bus(); step();
      addr = 8'h00; rw = 1; lds = 1; step();
      checks++; if (data_read !== 16'h0000) begin errors++; $display("FAIL spurious_pending: got %h want 0000", data_read); end
      idle_bus(); step();
   endtask

   task automatic test_collision();
      int ack_cnt;
      irq = 7'h01; step();
      addr = 8'h00; rw = 0; lds = 1; data_write = 16'h0001; step();
      idle_bus(); irq = 0; step();
      addr = 8'h00; rw = 1; lds = 1; step();
      checks++; if (data_read[0] !== 1'b1 || data_read !== m_rd) begin errors++;
         $display("FAIL collision_pending: got %h want bit0 set (model %h)", data_read, m_rd); end
      idle_bus(); step();
      ack_cnt = 0;
      addr = 8'h06; rw = 1; lds = 1;
      repeat (5) begin step(); ack_cnt += int'(ack); end
      idle_bus(); step(); ack_cnt += int'(ack);
      checks++; if (ack_cnt != 1) begin errors++; $display("FAIL held_strobe_acks: got %0d want 1", ack_cnt); end
      addr = 8'h00; rw = 0; lds = 1; data_write = 16'h007F; step(); idle_bus(); step();
   endtask

   task automatic test_timer();
      irq = 7'h20; repeat (20) step();
      addr = 8'h00; rw = 1; lds = 1; step();
      checks++; if (data_read !== 16'h0020) begin errors++; $display("FAIL timer_single: got %h want 0020", data_read); end
      idle_bus(); step();
      iack = 1; addr = 8'h0C; step();
      checks++; if (data_read !== 16'h0046) begin errors++; $display("FAIL timer_iack: got %h want 0046", data_read); end
      idle_bus(); repeat (5) step();
      addr = 8'h00; rw = 1; lds = 1; step();
      checks++; if (data_read !== 16'h0000) begin errors++; $display("FAIL timer_no_reset: got %h want 0000", data_read); end
      idle_bus(); irq = 0; step(); step(); irq = 7'h20; step(); step(); step();
      addr = 8'h00; rw = 1; lds = 1; step();
      checks++; if (data_read !== 16'h0020) begin errors++; $display("FAIL timer_rearm: got %h want 0020", data_read); end
      idle_bus(); irq = 0; step();
      addr = 8'h00; rw = 0; lds = 1; data_write = 16'h007F; step(); idle_bus(); step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < 7; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
         if ($urandom_range(0, 3) == 0) begin
            iack = ($urandom_range(0, 2) == 0);
            lds  = $urandom_range(0, 1) != 0;
            uds  = $urandom_range(0, 1) != 0;
            rw   = $urandom_range(0, 1) != 0;
            addr = 8'($urandom_range(0, 15));
            data_write = 16'($urandom);
         end else idle_bus();
         step();
         checks++; if (ack !== m_ack) begin errors++; $display("FAIL rand_ack cyc %0d: got %b want %b", c, ack, m_ack); end
         checks++; if (data_read !== m_rd) begin errors++; $display("FAIL rand_data_read cyc %0d: got %h want %h", c, data_read, m_rd); end
         checks++; if (ipl_n !== m_ipl_n) begin errors++; $display("FAIL rand_ipl_n cyc %0d: got %b want %b", c, ipl_n, m_ipl_n); end
      end
      idle_bus(); irq = 0; step(); step();
   endtask

   task automatic test_async_reset();
      addr = 8'h02; rw = 0; lds = 1; data_write = 16'h007F; step(); idle_bus(); step();
      irq = 7'h40; step(); irq = 0; step(); step();
      addr = 8'h00; rw = 1; lds = 1; step();
      checks++; if (ack !== 1'b1 || ipl_n !== 3'b000) begin errors++;
         $display("FAIL pre_reset_state: got ack=%b ipl_n=%b want ack=1 ipl_n=000", ack, ipl_n); end
      #2 reset = 1'b1;
      #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL async_reset_ack: got %b want 0", ack); end
      checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL async_reset_ipl_n: got %b want 111", ipl_n); end
      checks++; if (data_read !== 16'd0) begin errors++; $display("FAIL async_reset_data_read: got %h want 0000", data_read); end
      idle_bus();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      step();
      checks++; if (ack !== 1'b0 || ipl_n !== 3'b111) begin errors++;
         $display("FAIL post_reset_state: got ack=%b ipl_n=%b want ack=0 ipl_n=111", ack, ipl_n); end
   endtask

   initial begin
      reset = 1'b1; irq = 0; idle_bus();
      model_reset();
      test_reset();
      test_mask();
      test_priority_iack();
      test_spurious();
      test_collision();
      test_timer();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard bound on run time
   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
